// File: rtl/rom_port_arbiter_pkg.sv
// Shared constants for the two-requester pixel-ROM arbiter.
package rom_arb_pkg;

  // Default geometry: 160x120 tiles, 3-bit palette index.
  localparam int ADDR_BITS = 15;
  localparam int ROM_DEPTH = 19200;
  localparam int PIX_BITS  = 3;

  // Requester indices into req_i / gnt_o / rvalid_o.
  localparam int BG_REQ  = 0;
  localparam int SPR_REQ = 1;

endpackage : rom_arb_pkg

// File: rtl/rom_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: purely combinational (req, last) -> gnt.
module rr_pick2
  import rom_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,  // index of the requester granted most recently
  output logic [1:0] o_gnt
);

  // Pick the lone requester, or the one not granted last when both ask.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    o_gnt = '0;
    if (i_req[BG_REQ] && i_req[SPR_REQ]) begin
      if (i_last) o_gnt[BG_REQ]  = 1'b1;
      else        o_gnt[SPR_REQ] = 1'b1;
    end else begin
      o_gnt = i_req;
    end
  end

endmodule : rr_pick2

// File: rtl/rom_port_arbiter.sv
// Shares one external synchronous pixel ROM between the background and
// sprite fetchers. Grants are combinational in the request cycle; data and
// the out-of-range flag return exactly one cycle later.
module rom_port_arbiter #(
  parameter int ADDR_BITS = rom_arb_pkg::ADDR_BITS,
  parameter int ROM_DEPTH = rom_arb_pkg::ROM_DEPTH,
  parameter int PIX_BITS  = rom_arb_pkg::PIX_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_i,
  input  logic [ADDR_BITS-1:0] addr0_i,
  input  logic [ADDR_BITS-1:0] addr1_i,
  output logic [1:0]           gnt_o,
  output logic [1:0]           rvalid_o,
  output logic [PIX_BITS-1:0]  rdata_o,
  output logic                 rerr_o,
  output logic [ADDR_BITS-1:0] rom_addr_o,
  input  logic [PIX_BITS-1:0]  rom_data_i
);

  import rom_arb_pkg::BG_REQ;
  import rom_arb_pkg::SPR_REQ;

  logic                 r_last;    // requester granted most recently
  logic [1:0]           r_rvalid;  // return tag: who was granted last cycle
  logic                 r_oob;     // last cycle's granted address was out of range

  logic [1:0]           w_pick;
  logic [1:0]           w_gnt;
  logic [ADDR_BITS-1:0] w_addr;
  logic                 w_oob;

  rr_pick2 u_pick (
    .i_req  (req_i),
    .i_last (r_last),
    .o_gnt  (w_pick)
  );

  // Reset suppresses the grant, so nothing from the reset cycle returns data.
  assign w_gnt = rst ? 2'b00 : w_pick;
  assign gnt_o = w_gnt;

  // Steer the granted requester's address to the ROM; zero when idle.
  always_comb begin
    w_addr = '0;
    if (w_gnt[BG_REQ])       w_addr = addr0_i;
    else if (w_gnt[SPR_REQ]) w_addr = addr1_i;
  end

  assign rom_addr_o = w_addr;

  // Full-width unsigned compare; both sides widened to 32 bits so neither
  // the address nor the depth is truncated.
  assign w_oob = (32'(w_addr) >= 32'(ROM_DEPTH));

  // Last-grant pointer: moves on every grant, holds when idle. Reset points
  // it at the sprite side so the background fetch wins the first contention.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_gnt[BG_REQ]) begin
      r_last <= 1'b0;
    end else if (w_gnt[SPR_REQ]) begin
      r_last <= 1'b1;
    end
  end

  // One-stage return pipeline aligned with the ROM's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 2'b00;
      r_oob    <= 1'b0;
    end else begin
      r_rvalid <= w_gnt;
      r_oob    <= w_oob & (|w_gnt);
    end
  end

  // Data and error are forced to zero unless a read is returning.
  assign rvalid_o = r_rvalid;
  assign rerr_o   = (|r_rvalid) & r_oob;
  assign rdata_o  = ((|r_rvalid) && !r_oob) ? rom_data_i : '0;

endmodule : rom_port_arbiter

// File: tb/tb_rom_port_arbiter.sv
// Directed, table-driven bench for rom_port_arbiter with a behavioural
// synchronous ROM model.
module tb_rom_port_arbiter;

  localparam int AW = 15;
  localparam int PW = 3;

  logic          clk;
  logic          rst;
  logic [1:0]    req_i;
  logic [AW-1:0] addr0_i;
  logic [AW-1:0] addr1_i;
  logic [1:0]    gnt_o;
  logic [1:0]    rvalid_o;
  logic [PW-1:0] rdata_o;
  logic          rerr_o;
  logic [AW-1:0] rom_addr_o;
  logic [PW-1:0] rom_data_i;

  int n_checks = 0;
  int n_errors = 0;

  rom_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .addr0_i    (addr0_i),
    .addr1_i    (addr1_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .rerr_o     (rerr_o),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: nonzero at the out-of-range probe addresses so a leaked
  // ROM word would be visible.
  function automatic logic [PW-1:0] rom_fn(input logic [AW-1:0] a);
    return (a[2:0] + 3'd5) ^ a[5:3];
  endfunction

  // External synchronous ROM: data one cycle after the address.
  always_ff @(posedge clk) rom_data_i <= rom_fn(rom_addr_o);

  typedef struct {
    logic          rst;
    logic [1:0]    req;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [1:0]    gnt;
    logic [AW-1:0] addr;
    logic [1:0]    rv;
    logic [PW-1:0] rd;
    logic          re;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [1:0] rq, int a0, int a1,
                              logic [1:0] g, int ad, logic [1:0] rv,
                              logic [PW-1:0] rd, logic re);
    vec_t v;
    v.rst = r;  v.req = rq;  v.a0 = AW'(a0);  v.a1 = AW'(a1);
    v.gnt = g;  v.addr = AW'(ad);  v.rv = rv;  v.rd = rd;  v.re = re;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then sample every
  // output mid-cycle, well away from the rising edge.
  task automatic apply(input logic r, input logic [1:0] rq,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    @(negedge clk);
    rst = r;  req_i = rq;  addr0_i = a0;  addr1_i = a1;
    #2;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] g,
                            input logic [AW-1:0] ad, input logic [1:0] rv,
                            input logic [PW-1:0] rd, input logic re);
    check({tag, " gnt"},      32'(gnt_o),      32'(g));
    check({tag, " rom_addr"}, 32'(rom_addr_o), 32'(ad));
    check({tag, " rvalid"},   32'(rvalid_o),   32'(rv));
    check({tag, " rdata"},    32'(rdata_o),    32'(rd));
    check({tag, " rerr"},     32'(rerr_o),     32'(re));
  endtask

  initial begin
    logic [1:0]    prev_g;
    logic [AW-1:0] prev_a;
    logic [1:0]    exp_g;
    logic [AW-1:0] exp_a;

    rst = 1'b1;  req_i = 2'b00;  addr0_i = '0;  addr1_i = '0;
    repeat (2) @(posedge clk);

    // Reset, then continuous contention: 0,1,0,1 with one-cycle return.
    vecs.push_back(mk(1, 2'b11, 5, 7, 2'b00, 0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b11, 5, 7, 2'b01, 5, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b11, 5, 7, 2'b10, 7, 2'b01, rom_fn(5), 0));
    vecs.push_back(mk(0, 2'b11, 5, 7, 2'b01, 5, 2'b10, rom_fn(7), 0));
    vecs.push_back(mk(0, 2'b11, 5, 7, 2'b10, 7, 2'b01, rom_fn(5), 0));
    // Background only, addresses 0..3 back to back.
    vecs.push_back(mk(0, 2'b01, 0, 7, 2'b01, 0, 2'b10, rom_fn(7), 0));
    vecs.push_back(mk(0, 2'b01, 1, 7, 2'b01, 1, 2'b01, rom_fn(0), 0));
    vecs.push_back(mk(0, 2'b01, 2, 7, 2'b01, 2, 2'b01, rom_fn(1), 0));
    vecs.push_back(mk(0, 2'b01, 3, 7, 2'b01, 3, 2'b01, rom_fn(2), 0));
    // Sprite range boundary: 19200 and 32767 out of range, 19199 in range.
    vecs.push_back(mk(0, 2'b10, 0, 19200, 2'b10, 19200, 2'b01, rom_fn(3), 0));
    vecs.push_back(mk(0, 2'b10, 0, 32767, 2'b10, 32767, 2'b10, 0, 1));
    vecs.push_back(mk(0, 2'b10, 0, 19199, 2'b10, 19199, 2'b10, 0, 1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 0, 2'b10, rom_fn(19199), 0));
    // Ten idle cycles; pointer still says sprite was last.
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b11, 5, 7, 2'b01, 5, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b11, 5, 7, 2'b10, 7, 2'b01, rom_fn(5), 0));
    // Reset while the sprite side would be granted: no grant, no return.
    vecs.push_back(mk(1, 2'b10, 5, 7, 2'b00, 0, 2'b10, rom_fn(7), 0));
    vecs.push_back(mk(0, 2'b11, 5, 7, 2'b01, 5, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b00, 5, 7, 2'b00, 0, 2'b01, rom_fn(5), 0));
    vecs.push_back(mk(0, 2'b00, 5, 7, 2'b00, 0, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b00, 5, 7, 2'b00, 0, 2'b00, 0, 0));
    // Background was last, so the sprite wins after the idle gap.
    vecs.push_back(mk(0, 2'b11, 5, 7, 2'b10, 7, 2'b00, 0, 0));

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].req, vecs[i].a0, vecs[i].a1);
      check_outs($sformatf("v%0d", i), vecs[i].gnt, vecs[i].addr,
                 vecs[i].rv, vecs[i].rd, vecs[i].re);
    end

    // Contention with a fresh address every cycle: strict alternation,
    // each return carrying the previous cycle's grant and data.
    prev_g = 2'b10;
    prev_a = AW'(7);
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 2'b11, AW'(100 + i), AW'(200 + i));
      exp_g = (prev_g == 2'b01) ? 2'b10 : 2'b01;
      exp_a = (exp_g == 2'b01) ? AW'(100 + i) : AW'(200 + i);
      check_outs($sformatf("alt%0d", i), exp_g, exp_a, prev_g,
                 rom_fn(prev_a), 1'b0);
      prev_g = exp_g;
      prev_a = exp_a;
    end
    apply(1'b0, 2'b00, '0, '0);
    check_outs("alt_tail", 2'b00, '0, prev_g, rom_fn(prev_a), 1'b0);
    apply(1'b0, 2'b00, '0, '0);
    check_outs("idle_end", 2'b00, '0, 2'b00, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_rom_port_arbiter
